apb4_sram: RTL and testbench

//  APB4 slave SRAM, successor to the basic APB SRAM. Adds parametrised data width,

---
 rtl/apb4_sram.sv | 150 +++++++++++++++
 tb/tb_apb4_sram.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_sram.sv
// apb4_sram: APB4 slave scratch/mailbox SRAM.
//   Word-organised memory with byte-lane write strobes, a fixed number of
//   PREADY wait states per access phase, and PSLVERR for out-of-range addresses.
//
// Parameters
//   SIZE_IN_BYTES  memory size in bytes (power of 2, >= DATA_WIDTH/8)
//   DATA_WIDTH     data bus width, 32 or 64
//   ADDR_WIDTH     address bus width
//   WAIT_STATES    PREADY-low cycles inserted per access phase, 0..15
//
// Ports
//   PCLK     clock, rising edge
//   PRESETn  asynchronous active-low reset
//   PSEL     slave select
//   PENABLE  access phase strobe
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address; lane-offset bits ignored
//   PWDATA   write data
//   PSTRB    byte-lane write enables (writes only)
//   PRDATA   read data, loaded at the setup edge of a read
//   PREADY   transfer completes when high in the access phase
//   PSLVERR  error response, qualified by PREADY
module apb4_sram #(
  parameter int SIZE_IN_BYTES = 1024,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int WAIT_STATES   = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(NUM_LANES);
  localparam int DEPTH     = SIZE_IN_BYTES / NUM_LANES;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so the size limit itself is representable when
  // SIZE_IN_BYTES == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] SIZE_LIMIT = (ADDR_WIDTH+1)'(SIZE_IN_BYTES);
  localparam logic [3:0]          WAIT_LAST  = 4'(WAIT_STATES);
  localparam logic [IDX_W-1:0]    IDX_MASK   = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    err_q, err_d;
  logic                    wr_q, wr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        paddr_idx;
  logic                    addr_err;
  logic                    setup_phase;
  logic                    ready;
  logic                    commit;

  // Masking keeps the index inside the array even when DEPTH is 1.
  assign paddr_idx   = IDX_W'(PADDR >> LSB) & IDX_MASK;
  assign addr_err    = ({1'b0, PADDR} >= SIZE_LIMIT);
  assign setup_phase = (state_q == S_IDLE) && PSEL && !PENABLE;
  assign ready       = (state_q == S_ACCESS) && (wcnt_q == WAIT_LAST);
  // Writes land only on the completing edge; an abort or reset drops them.
  assign commit      = ready && PSEL && PENABLE && wr_q && !err_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    case (state_q)
      S_IDLE: begin
        if (setup_phase) begin
          state_d = S_ACCESS;
          wcnt_d  = 4'd0;
          err_d   = addr_err;
          wr_d    = PWRITE;
          idx_d   = paddr_idx;
          // Read data is fetched at setup and held until the next read setup.
          if (!PWRITE) begin
            prdata_d = addr_err ? '0 : mem[paddr_idx];
          end
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (PENABLE) begin
          if (ready) begin
            state_d = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      wcnt_q   <= 4'd0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
    end
  end

  // Storage is deliberately not reset so contents survive PRESETn.
  always_ff @(posedge PCLK) begin
    if (commit) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (PSTRB[i]) begin
          mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;

endmodule

// File: tb/tb_apb4_sram.sv
// tb_apb4_sram: randomized self-checking bench for apb4_sram.
//   Two instances share one APB bus with separate PSEL lines:
//   dut_a (32-bit, no wait states) and dut_b (64-bit, 3 wait states).
//   A byte-addressed reference memory per instance predicts read data.
module tb_apb4_sram;

  localparam int SIZE = 1024;
  localparam int WS_A = 0;
  localparam int WS_B = 3;

  logic        pclk;
  logic        prstn;
  logic        psel_a, psel_b;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [31:0] prdata_a;
  logic [63:0] prdata_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [2][SIZE];

  apb4_sram #(.SIZE_IN_BYTES(SIZE), .DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(WS_A)) dut_a (
    .PCLK(pclk), .PRESETn(prstn), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb4_sram #(.SIZE_IN_BYTES(SIZE), .DATA_WIDTH(64), .ADDR_WIDTH(32), .WAIT_STATES(WS_B)) dut_b (
    .PCLK(pclk), .PRESETn(prstn), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int lanes(input int dev);
    return (dev == 0) ? 4 : 8;
  endfunction

  function automatic void model_write(input int dev, input logic [31:0] addr,
                                      input logic [63:0] wdata, input logic [7:0] strb);
    int base;
    if (addr >= SIZE) return;
    base = int'(addr) - (int'(addr) % lanes(dev));
    for (int i = 0; i < lanes(dev); i++)
      if (strb[i]) ref_mem[dev][base + i] = wdata[8*i +: 8];
  endfunction

  function automatic logic [63:0] model_read(input int dev, input logic [31:0] addr);
    logic [63:0] r;
    int base;
    r = 64'h0;
    if (addr >= SIZE) return r;
    base = int'(addr) - (int'(addr) % lanes(dev));
    for (int i = 0; i < lanes(dev); i++)
      r[8*i +: 8] = ref_mem[dev][base + i];
    return r;
  endfunction

  function automatic int exp_cycles(input int dev);
    return ((dev == 0) ? WS_A : WS_B) + 1;
  endfunction

  // ---------------- bus driver ----------------
  // acc_cycles: access-phase cycles up to and including PREADY=1 (-1 on timeout).
  // idle_rdy:   PREADY observed during the setup cycle.
  task automatic apb_xfer(input int dev, input logic wr, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          output logic [63:0] rdata, output logic err,
                          output int acc_cycles, output logic idle_rdy);
    logic rdy;
    @(posedge pclk); #1;
    psel_a = (dev == 0); psel_b = (dev == 1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge pclk);
    idle_rdy = (dev == 0) ? pready_a : pready_b;
    @(posedge pclk); #1;
    penable = 1'b1;
    acc_cycles = -1; rdata = 64'h0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge pclk);
      rdy = (dev == 0) ? pready_a : pready_b;
      if (rdy) begin
        acc_cycles = n;
        rdata = (dev == 0) ? {32'h0, prdata_a} : prdata_b;
        err   = (dev == 0) ? pslverr_a : pslverr_b;
        break;
      end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    prstn = 1'b0; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if ({pready_a, pslverr_a, prdata_a} !== 34'h0) begin
      failures++;
      $display("FAIL reset_a: got rdy=%b err=%b rd=%h want 0 0 0", pready_a, pslverr_a, prdata_a);
    end
    checks++;
    if ({pready_b, pslverr_b, prdata_b} !== 66'h0) begin
      failures++;
      $display("FAIL reset_b: got rdy=%b err=%b rd=%h want 0 0 0", pready_b, pslverr_b, prdata_b);
    end
    prstn = 1'b1;
  endtask

  task automatic test_fill;
    logic [63:0] rd, wd; logic er, ir; int cyc; int bad;
    bad = 0;
    for (int dev = 0; dev < 2; dev++) begin
      for (int a = 0; a < SIZE; a += lanes(dev)) begin
        wd = {$urandom, $urandom};
        apb_xfer(dev, 1'b1, a, wd, 8'hFF, rd, er, cyc, ir);
        model_write(dev, a, wd, 8'hFF);
        if (er !== 1'b0 || cyc != exp_cycles(dev)) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill: got %0d bad write responses want 0", bad);
    end
  endtask

  task automatic test_basic;
    logic [63:0] rd; logic er, ir; int cyc;
    apb_xfer(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'h0F, rd, er, cyc, ir);
    model_write(0, 32'h10, 64'hDEADBEEF, 8'h0F);
    checks++;
    if (cyc != 1 || er !== 1'b0 || ir !== 1'b0) begin
      failures++;
      $display("FAIL basic_wr: got cyc=%0d err=%b idle_rdy=%b want 1 0 0", cyc, er, ir);
    end
    apb_xfer(0, 1'b0, 32'h10, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== 64'hDEADBEEF || cyc != 1 || er !== 1'b0 || ir !== 1'b0) begin
      failures++;
      $display("FAIL basic_rd: got rd=%h cyc=%0d err=%b want deadbeef 1 0", rd, cyc, er);
    end
  endtask

  task automatic test_wait_states;
    logic [63:0] rd, exp; logic er, ir; int cyc;
    exp = model_read(1, 32'h04);
    apb_xfer(1, 1'b0, 32'h04, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (cyc != 4 || ir !== 1'b0 || er !== 1'b0) begin
      failures++;
      $display("FAIL wait_cycles: got access=%0d idle_rdy=%b err=%b want 4 0 0", cyc, ir, er);
    end
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL wait_data: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_strobes;
    logic [63:0] rd; logic er, ir; int cyc;
    apb_xfer(0, 1'b1, 32'h20, 64'h11223344, 8'h0F, rd, er, cyc, ir);
    model_write(0, 32'h20, 64'h11223344, 8'h0F);
    apb_xfer(0, 1'b1, 32'h20, 64'hAABBCCDD, 8'h05, rd, er, cyc, ir);
    model_write(0, 32'h20, 64'hAABBCCDD, 8'h05);
    apb_xfer(0, 1'b0, 32'h20, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== 64'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_merge: got %h want 11bb33dd", rd);
    end
    // All strobes low must leave the word untouched.
    apb_xfer(0, 1'b1, 32'h20, 64'hFFFFFFFF, 8'h00, rd, er, cyc, ir);
    apb_xfer(0, 1'b0, 32'h20, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== model_read(0, 32'h20)) begin
      failures++;
      $display("FAIL strobe_zero: got %h want %h", rd, model_read(0, 32'h20));
    end
  endtask

  task automatic test_error;
    logic [63:0] rd, exp0; logic er, ir; int cyc;
    exp0 = model_read(0, 32'h0);
    apb_xfer(0, 1'b1, SIZE, 64'h12345678, 8'h0F, rd, er, cyc, ir);
    checks++;
    if (er !== 1'b1 || cyc != 1) begin
      failures++;
      $display("FAIL err_wr: got err=%b cyc=%0d want 1 1", er, cyc);
    end
    apb_xfer(0, 1'b0, 32'h0, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== exp0 || er !== 1'b0) begin
      failures++;
      $display("FAIL err_alias: got rd=%h err=%b want %h 0", rd, er, exp0);
    end
    apb_xfer(0, 1'b0, SIZE + 4, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      failures++;
      $display("FAIL err_rd: got rd=%h err=%b want 0 1", rd, er);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd, exp; logic er, ir; int cyc;
    apb_xfer(1, 1'b1, 32'h30, 64'hCAFEF00D12345678, 8'hFF, rd, er, cyc, ir);
    model_write(1, 32'h30, 64'hCAFEF00D12345678, 8'hFF);
    apb_xfer(1, 1'b0, 32'h30, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== 64'hCAFEF00D12345678) begin
      failures++;
      $display("FAIL rstmid_pre: got %h want cafef00d12345678", rd);
    end
    @(posedge pclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
    pwdata = 64'h5555AAAA5555AAAA; pstrb = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (WS_B) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if (pready_b !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready: got %b want 1", pready_b);
    end
    prstn = 1'b0;
    #1;
    checks++;
    if ({pready_b, pslverr_b, prdata_b} !== 66'h0) begin
      failures++;
      $display("FAIL rstmid_out: got rdy=%b err=%b rd=%h want 0 0 0", pready_b, pslverr_b, prdata_b);
    end
    repeat (2) @(posedge pclk);
    #1;
    psel_b = 1'b0; penable = 1'b0;
    @(negedge pclk);
    prstn = 1'b1;
    exp = model_read(1, 32'h30);
    apb_xfer(1, 1'b0, 32'h30, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL rstmid_keep: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_wide;
    logic [63:0] rd, exp; logic [31:0] low_before; logic er, ir; int cyc;
    low_before = model_read(1, 32'h08) & 64'hFFFF_FFFF;
    apb_xfer(1, 1'b1, 32'h08, 64'h0123456789ABCDEF, 8'hF0, rd, er, cyc, ir);
    model_write(1, 32'h08, 64'h0123456789ABCDEF, 8'hF0);
    exp = model_read(1, 32'h08);
    apb_xfer(1, 1'b0, 32'h08, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd[63:32] !== 32'h01234567 || rd[31:0] !== low_before) begin
      failures++;
      $display("FAIL wide_lanes: got %h want %h_%h", rd, 32'h01234567, low_before);
    end
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL wide_model: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_abort;
    logic [63:0] rd, exp; logic er, ir; int cyc;
    exp = model_read(1, 32'h40);
    @(posedge pclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
    pwdata = ~exp; pstrb = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if (pready_b !== 1'b0 || pslverr_b !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got rdy=%b err=%b want 0 0", pready_b, pslverr_b);
    end
    apb_xfer(1, 1'b0, 32'h40, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL abort_nowrite: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_penable_only;
    logic [63:0] rd, exp; logic er, ir; int cyc; int hi;
    exp = model_read(0, 32'h14);
    hi = 0;
    @(posedge pclk); #1;
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h14;
    pwdata = ~exp; pstrb = 8'h0F;
    repeat (4) begin
      @(negedge pclk);
      if (pready_a !== 1'b0) hi++;
    end
    @(posedge pclk); #1;
    psel_a = 1'b0; penable = 1'b0;
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL penable_only_rdy: got %0d ready cycles want 0", hi);
    end
    apb_xfer(0, 1'b0, 32'h14, 64'h0, 8'h0, rd, er, cyc, ir);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL penable_only_mem: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd, wd; logic [31:0] a; logic [7:0] s; logic er, ir; int cyc;
    for (int k = 0; k < 16; k++) begin
      int dev;
      dev = k % 2;
      a = $urandom_range(0, SIZE - 1);
      wd = {$urandom, $urandom};
      s = 8'($urandom);
      apb_xfer(dev, 1'b1, a, wd, s, rd, er, cyc, ir);
      model_write(dev, a, wd, s);
      apb_xfer(dev, 1'b0, a, 64'h0, 8'h0, rd, er, cyc, ir);
      checks++;
      if (rd !== model_read(dev, a)) begin
        failures++;
        $display("FAIL b2b dev%0d @%h: got %h want %h", dev, a, rd, model_read(dev, a));
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, wd, exp; logic [31:0] a; logic [7:0] s; logic wr, er, ir; int cyc;
    for (int k = 0; k < 200; k++) begin
      int dev, r;
      dev = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      a = SIZE + $urandom_range(0, SIZE - 1);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, SIZE - 1);
      wr = 1'($urandom);
      wd = {$urandom, $urandom};
      s  = 8'($urandom);
      exp = model_read(dev, a);
      apb_xfer(dev, wr, a, wd, s, rd, er, cyc, ir);
      checks++;
      if (er !== (a >= SIZE) || cyc != exp_cycles(dev) || ir !== 1'b0) begin
        failures++;
        $display("FAIL rand_resp dev%0d @%h: got err=%b cyc=%0d idle_rdy=%b want %b %0d 0",
                 dev, a, er, cyc, ir, (a >= SIZE), exp_cycles(dev));
      end
      if (wr) begin
        model_write(dev, a, wd, s);
      end else begin
        checks++;
        if (rd !== exp) begin
          failures++;
          $display("FAIL rand_rd dev%0d @%h: got %h want %h", dev, a, rd, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_basic;
    test_wait_states;
    test_strobes;
    test_error;
    test_reset_mid;
    test_wide;
    test_abort;
    test_penable_only;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
